rvx_dma: RTL and testbench
==========================

RVX_DMA -- requirements
Module: rvx_dma

Interface
REQ-001 Parameter: COUNT_WIDTH, 16, width of the transfer word-count register (1..32).
REQ-002 clock  input  1  system clock; all state changes on the rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 rw_address  input  5  device-port register byte offset.
REQ-005 read_data  output  32  device-port read data, valid while read_response is high.
REQ-006 read_request / read_response  input / output  1 each  device-port read handshake.
REQ-007 write_data  input  32  device-port write data.
REQ-008 write_strobe  input  4  device-port byte enables.
REQ-009 write_request / write_response  input / output  1 each  device-port write handshake.
REQ-010 m_rw_address  output  32  manager-port address, always word-aligned.
REQ-011 m_read_data  input  32  manager-port read data, sampled when m_read_response is high.
REQ-012 m_read_request / m_read_response  output / input  1 each  manager-port read handshake.
REQ-013 m_write_data  output  32  manager-port write data.
REQ-014 m_write_strobe  output  4  manager-port byte enables, constant 4'b1111.
REQ-015 m_write_request / m_write_response  output / input  1 each  manager-port write handshake.
REQ-016 irq / irq_response  output / input  1 each  completion interrupt and its acknowledge.

Function
REQ-017 Register map (offset: register): 0x00 SRC; 0x04 DST; 0x08 COUNT (COUNT_WIDTH bits, zero-extended on read); 0x0C CTRL. CTRL bits: bit0 start (write-1, reads 0); bit1 busy (RO); bit2 done (sticky, write-1-clear); bit3 irq_en (RW).
REQ-018 Device port: read_response and write_response pulse high exactly one cycle after the request cycle, for one cycle; read_data is zero when read_response is low.
REQ-019 SRC, DST and COUNT writes honour write_strobe per byte. SRC/DST bits [1:0] always read 0.
REQ-020 CTRL writes act only when write_strobe[0]=1.
REQ-021 Unmapped offsets: reads return 0, writes are ignored, and a response is still given.
REQ-022 While busy, writes to SRC, DST and COUNT are ignored and start is ignored; irq_en and done-clear remain writable.
REQ-023 FSM states IDLE, READ, WRITE.
REQ-024 IDLE->READ on start when COUNT != 0. The block latches working copies of SRC, DST and remaining count, and clears done.
REQ-025 Start with COUNT == 0 stays in IDLE, sets done on the next cycle and issues no bus request.
REQ-026 READ: m_read_request=1 with m_rw_address=src_ptr, held stable until the cycle m_read_response=1. In that cycle m_read_data is captured into a data register, the request drops the next cycle, and the FSM moves READ->WRITE.
REQ-027 WRITE: m_write_request=1 with m_rw_address=dst_ptr and m_write_data=captured data, held until m_write_response=1. In that cycle src_ptr+=4, dst_ptr+=4 and remaining-=1.
REQ-028 After WRITE: if remaining reaches 0, go to IDLE and set done; otherwise go to READ.
REQ-029 Minimum spacing: one idle manager cycle between consecutive requests.
REQ-030 Pointers wrap modulo 2^32 (0xFFFFFFFC+4=0x00000000) with no error.
REQ-031 m_read_request and m_write_request are never high together.
REQ-032 Requests assert only from state registers (no combinational path from inputs).
REQ-033 The SRC, DST and COUNT registers are not modified by a transfer; a re-start repeats the transfer.
REQ-034 busy = (state != IDLE).
REQ-035 irq = done & irq_en, registered.
REQ-036 irq_response=1 clears done; if it coincides with done being set, the set wins.
REQ-037 A CTRL write with start=1 and done-clear in the same write starts the transfer, leaving done=0.

Reset
REQ-038 On reset_n low (asynchronous), all registers clear: SRC, DST, COUNT, CTRL = 0.
REQ-039 On reset_n low, the FSM goes to IDLE.
REQ-040 On reset_n low, all outputs are 0 except m_write_strobe=4'b1111.
REQ-041 Reset mid-transfer drops any pending manager request immediately; the bench ignores any late response.

Verification
REQ-042 Write SRC=0x100, DST=0x200, COUNT=3, CTRL=0x9. Required: reads of 0x100/0x104/0x108 each followed by writes to 0x200/0x204/0x208 with matching data; then done=1, irq=1, busy=0.
REQ-043 Start with COUNT=0. Required: no m_*_request ever; done=1 two cycles after the write request.
REQ-044 Responder with 5-cycle response delay, COUNT=2. Required: address, data and request held stable for the full wait; exactly 2 reads and 2 writes.
REQ-045 SRC=0xFFFFFFFC, COUNT=2. Required: second read targets 0x00000000.
REQ-046 While busy, write COUNT=9 and start again. Required: COUNT reads back unchanged; the transfer completes the original length only.
REQ-047 Assert reset_n=0 during a WRITE wait. Required: requests drop the same cycle; all registers read 0 after release.

Source files
------------

// File: rtl/rvx_dma.sv
// rvx_dma: register-programmed word-copy DMA engine with a device register port and a manager bus port.
module rvx_dma #(
   parameter int COUNT_WIDTH = 16
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [4:0]  rw_address,
   output logic [31:0] read_data,
   input  logic        read_request,
   output logic        read_response,
   input  logic [31:0] write_data,
   input  logic [3:0]  write_strobe,
   input  logic        write_request,
   output logic        write_response,
   output logic [31:0] m_rw_address,
   input  logic [31:0] m_read_data,
   output logic        m_read_request,
   input  logic        m_read_response,
   output logic [31:0] m_write_data,
   output logic [3:0]  m_write_strobe,
   output logic        m_write_request,
   input  logic        m_write_response,
   output logic        irq,
   input  logic        irq_response
);
   typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
   state_t state;
   logic [31:0] src, dst, src_ptr, dst_ptr, wmask, src_m, dst_m, rd_mux;
   logic [COUNT_WIDTH-1:0] count, remaining, cnt_m;
   logic done, irq_en, busy, wr_src, wr_dst, wr_cnt, wr_ctrl;
   logic do_start, go, fin, done_set, done_clr;

   assign m_write_strobe = 4'b1111;
   assign busy = state != IDLE;
   assign wmask = {{8{write_strobe[3]}}, {8{write_strobe[2]}}, {8{write_strobe[1]}}, {8{write_strobe[0]}}};
   assign src_m = (src & ~wmask) | (write_data & wmask);
   assign dst_m = (dst & ~wmask) | (write_data & wmask);
   assign cnt_m = (count & ~wmask[COUNT_WIDTH-1:0]) | (write_data[COUNT_WIDTH-1:0] & wmask[COUNT_WIDTH-1:0]);
   assign wr_src = write_request && rw_address == 5'h00 && !busy;
   assign wr_dst = write_request && rw_address == 5'h04 && !busy;
   assign wr_cnt = write_request && rw_address == 5'h08 && !busy;
   assign wr_ctrl = write_request && rw_address == 5'h0C && write_strobe[0];
   assign do_start = wr_ctrl && write_data[0] && !busy;
   assign go = do_start && count != '0;
   assign fin = state == WRITE && m_write_request && m_write_response && remaining == COUNT_WIDTH'(1);
   // setting done (completion or empty start) wins over every clear source
   assign done_set = fin || (do_start && count == '0);
   assign done_clr = irq_response || (wr_ctrl && write_data[2]) || go;

   always_comb begin
      rd_mux = rw_address == 5'h00 ? src :
               rw_address == 5'h04 ? dst :
               rw_address == 5'h08 ? 32'(count) :
               rw_address == 5'h0C ? {28'd0, irq_en, done, busy, 1'b0} : 32'd0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         src <= '0;
         dst <= '0;
         count <= '0;
         done <= 1'b0;
         irq_en <= 1'b0;
         irq <= 1'b0;
         read_data <= '0;
         read_response <= 1'b0;
         write_response <= 1'b0;
      end else begin
         read_response <= read_request;
         write_response <= write_request;
         read_data <= read_request ? rd_mux : 32'd0;
         if (wr_src) src <= src_m & 32'hFFFF_FFFC;
         if (wr_dst) dst <= dst_m & 32'hFFFF_FFFC;
         if (wr_cnt) count <= cnt_m;
         if (wr_ctrl) irq_en <= write_data[3];
         done <= done_set || (done && !done_clr);
         irq <= done && irq_en;
      end
   end

   // each request is raised one cycle after entering its state, giving an idle manager cycle between requests
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         src_ptr <= '0;
         dst_ptr <= '0;
         remaining <= '0;
         m_rw_address <= '0;
         m_write_data <= '0;
         m_read_request <= 1'b0;
         m_write_request <= 1'b0;
      end else begin
         case (state)
            IDLE: if (go) begin
               state <= READ;
               src_ptr <= src;
               dst_ptr <= dst;
               remaining <= count;
            end
            READ: if (!m_read_request) begin
               m_read_request <= 1'b1;
               m_rw_address <= src_ptr;
            end else if (m_read_response) begin
               m_read_request <= 1'b0;
               m_write_data <= m_read_data;
               state <= WRITE;
            end
            WRITE: if (!m_write_request) begin
               m_write_request <= 1'b1;
               m_rw_address <= dst_ptr;
            end else if (m_write_response) begin
               m_write_request <= 1'b0;
               src_ptr <= src_ptr + 32'd4;
               dst_ptr <= dst_ptr + 32'd4;
               remaining <= remaining - COUNT_WIDTH'(1);
               state <= remaining == COUNT_WIDTH'(1) ? IDLE : READ;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rvx_dma.sv
// tb_rvx_dma: directed register vectors plus transfer sequences against a delay-configurable memory responder.
module tb_rvx_dma;
   logic clock = 0, reset_n = 0;
   logic [4:0] rw_address = '0;
   logic [31:0] read_data, write_data = '0, m_rw_address, m_read_data = '0, m_write_data;
   logic read_request = 0, read_response, write_request = 0, write_response;
   logic [3:0] write_strobe = '0, m_write_strobe;
   logic m_read_request, m_read_response = 0, m_write_request, m_write_response = 0;
   logic irq, irq_response = 0;

   int checks = 0, errors = 0, delay = 0, stab_err = 0, req_cnt = 0;
   bit mon_en = 1;
   logic [31:0] rd_log[$], wr_addr[$], wr_data[$];

   rvx_dma #(.COUNT_WIDTH(16)) dut (
      .clock(clock), .reset_n(reset_n), .rw_address(rw_address), .read_data(read_data),
      .read_request(read_request), .read_response(read_response), .write_data(write_data),
      .write_strobe(write_strobe), .write_request(write_request), .write_response(write_response),
      .m_rw_address(m_rw_address), .m_read_data(m_read_data), .m_read_request(m_read_request),
      .m_read_response(m_read_response), .m_write_data(m_write_data), .m_write_strobe(m_write_strobe),
      .m_write_request(m_write_request), .m_write_response(m_write_response),
      .irq(irq), .irq_response(irq_response)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic dev_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, output logic ok);
      rw_address = a;
      write_data = d;
      write_strobe = s;
      write_request = 1;
      @(posedge clock); #1;
      ok = write_response;
      write_request = 0;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      logic ok;
      dev_write(a, d, 4'hF, ok);
   endtask

   task automatic dev_read(input logic [4:0] a, output logic [31:0] d, output logic ok);
      rw_address = a;
      read_request = 1;
      @(posedge clock); #1;
      d = read_data;
      ok = read_response;
      read_request = 0;
   endtask

   task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
      logic [31:0] d;
      logic ok;
      dev_read(a, d, ok);
      chk({name, "_resp"}, 32'(ok), 32'd1);
      chk(name, d, exp);
   endtask

   task automatic wait_done(input string name);
      logic [31:0] d;
      logic ok;
      int n = 0;
      do begin
         dev_read(5'h0C, d, ok);
         n++;
      end while (d[1] && n < 300);
      chk({name, "_idle"}, 32'(d[1]), 32'd0);
   endtask

   task automatic check_xfer(input string name, input logic [31:0] s, input logic [31:0] dd, input int n);
      chk({name, "_nrd"}, rd_log.size(), n);
      chk({name, "_nwr"}, wr_addr.size(), n);
      for (int i = 0; i < n; i++) begin
         chk({name, "_rda"}, i < rd_log.size() ? rd_log[i] : 'x, s + 32'(4 * i));
         chk({name, "_wra"}, i < wr_addr.size() ? wr_addr[i] : 'x, dd + 32'(4 * i));
         chk({name, "_wrd"}, i < wr_data.size() ? wr_data[i] : 'x, mem(s + 32'(4 * i)));
      end
   endtask

   task automatic clear_logs();
      rd_log.delete();
      wr_addr.delete();
      wr_data.delete();
   endtask

   initial begin : responder
      int wait_cnt = 0;
      forever begin
         @(posedge clock); #1;
         m_read_response = 0;
         m_write_response = 0;
         m_read_data = 32'hDEAD_BEEF;
         if (m_read_request) begin
            if (wait_cnt == delay) begin
               m_read_response = 1;
               m_read_data = mem(m_rw_address);
               rd_log.push_back(m_rw_address);
               wait_cnt = 0;
            end else wait_cnt++;
         end else if (m_write_request) begin
            if (wait_cnt == delay) begin
               m_write_response = 1;
               wr_addr.push_back(m_rw_address);
               wr_data.push_back(m_write_data);
               wait_cnt = 0;
            end else wait_cnt++;
         end else wait_cnt = 0;
      end
   end

   initial begin : monitor
      logic p_rreq = 0, p_rresp = 0, p_wreq = 0, p_wresp = 0;
      logic [31:0] p_addr = '0, p_wdata = '0;
      forever begin
         @(negedge clock);
         if (mon_en && reset_n) begin
            if (m_read_request && m_write_request) stab_err++;
            if (p_rreq && !p_rresp && (!m_read_request || m_rw_address != p_addr)) stab_err++;
            if (p_wreq && !p_wresp && (!m_write_request || m_rw_address != p_addr || m_write_data != p_wdata)) stab_err++;
            if (((p_rreq && p_rresp) || (p_wreq && p_wresp)) && (m_read_request || m_write_request)) stab_err++;
            if (m_read_request || m_write_request) req_cnt++;
         end
         p_rreq = m_read_request;
         p_rresp = m_read_response;
         p_wreq = m_write_request;
         p_wresp = m_write_response;
         p_addr = m_rw_address;
         p_wdata = m_write_data;
      end
   end

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp;
   } vec_t;

   initial begin
      vec_t vecs[11];
      logic ok;
      int snap;
      vecs = '{
         '{5'h00, 32'h1234_5677, 4'hF, 32'h1234_5674},
         '{5'h00, 32'h0000_00FF, 4'h1, 32'h1234_56FC},
         '{5'h04, 32'hAABB_CCDD, 4'hC, 32'hAABB_0000},
         '{5'h04, 32'h1122_3344, 4'h2, 32'hAABB_3300},
         '{5'h08, 32'h0001_0005, 4'hF, 32'h0000_0005},
         '{5'h08, 32'hFFFF_0300, 4'h2, 32'h0000_0305},
         '{5'h0C, 32'h0000_0008, 4'hE, 32'h0000_0000},
         '{5'h0C, 32'h0000_0008, 4'h1, 32'h0000_0008},
         '{5'h0C, 32'h0000_0006, 4'h1, 32'h0000_0000},
         '{5'h10, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000},
         '{5'h1C, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000}
      };

      repeat (2) @(posedge clock);
      #1;
      chk("rst_rresp", 32'(read_response), 0);
      chk("rst_wresp", 32'(write_response), 0);
      chk("rst_mrreq", 32'(m_read_request), 0);
      chk("rst_mwreq", 32'(m_write_request), 0);
      chk("rst_maddr", m_rw_address, 0);
      chk("rst_strobe", 32'(m_write_strobe), 32'hF);
      chk("rst_irq", 32'(irq), 0);
      reset_n = 1;
      @(posedge clock); #1;
      rd_chk("rst_src", 5'h00, 0);
      rd_chk("rst_ctrl", 5'h0C, 0);

      for (int i = 0; i < 11; i++) begin
         dev_write(vecs[i].addr, vecs[i].data, vecs[i].strb, ok);
         chk($sformatf("vec%0d_wresp", i), 32'(ok), 1);
         rd_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
      end
      @(posedge clock); #1;
      chk("idle_rdata", read_data, 0);
      chk("idle_rresp", 32'(read_response), 0);

      // basic 3-word copy with interrupt
      clear_logs();
      wr(5'h00, 32'h100); wr(5'h04, 32'h200); wr(5'h08, 3); wr(5'h0C, 32'h9);
      wait_done("basic");
      check_xfer("basic", 32'h100, 32'h200, 3);
      rd_chk("basic_ctrl", 5'h0C, 32'hC);
      @(posedge clock); #1;
      chk("basic_irq", 32'(irq), 1);
      irq_response = 1;
      @(posedge clock); #1;
      irq_response = 0;
      rd_chk("ack_ctrl", 5'h0C, 32'h8);
      chk("ack_irq", 32'(irq), 0);
      rd_chk("basic_cnt_kept", 5'h08, 3);

      // empty start
      wr(5'h08, 0);
      snap = req_cnt;
      wr(5'h0C, 32'h1);
      rd_chk("zero_ctrl", 5'h0C, 32'h4);
      repeat (10) @(posedge clock);
      #1;
      chk("zero_noreq", req_cnt, snap);

      // start together with done-clear
      clear_logs();
      wr(5'h08, 1);
      wr(5'h0C, 32'h5);
      rd_chk("startclr_ctrl", 5'h0C, 32'h2);
      wait_done("startclr");
      rd_chk("startclr_done", 5'h0C, 32'h4);
      check_xfer("startclr", 32'h100, 32'h200, 1);

      // slow responder
      clear_logs();
      delay = 5;
      wr(5'h00, 32'h300); wr(5'h04, 32'h400); wr(5'h08, 2); wr(5'h0C, 32'h1);
      wait_done("slow");
      check_xfer("slow", 32'h300, 32'h400, 2);

      // source pointer wrap
      clear_logs();
      delay = 0;
      wr(5'h00, 32'hFFFF_FFFC); wr(5'h04, 32'h500); wr(5'h0C, 32'h1);
      wait_done("wrap");
      chk("wrap_nrd", rd_log.size(), 2);
      chk("wrap_rd1", rd_log.size() > 1 ? rd_log[1] : 'x, 32'h0);
      rd_chk("wrap_src_kept", 5'h00, 32'hFFFF_FFFC);

      // writes while busy are ignored
      clear_logs();
      delay = 3;
      wr(5'h00, 32'h800); wr(5'h04, 32'h900); wr(5'h08, 4); wr(5'h0C, 32'h1);
      wr(5'h08, 9);
      wr(5'h0C, 32'h1);
      rd_chk("busy_cnt", 5'h08, 4);
      wait_done("busy");
      check_xfer("busy", 32'h800, 32'h900, 4);

      // reset during a write wait
      delay = 20;
      wr(5'h00, 32'h600); wr(5'h04, 32'h700); wr(5'h08, 1); wr(5'h0C, 32'h9);
      for (int i = 0; i < 100 && !m_write_request; i++) begin
         @(posedge clock); #1;
      end
      chk("rst_wreq_seen", 32'(m_write_request), 1);
      mon_en = 0;
      #3 reset_n = 0;
      #1;
      chk("rst_mid_wreq", 32'(m_write_request), 0);
      chk("rst_mid_rreq", 32'(m_read_request), 0);
      chk("rst_mid_addr", m_rw_address, 0);
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1;
      mon_en = 1;
      rd_chk("post_src", 5'h00, 0);
      rd_chk("post_dst", 5'h04, 0);
      rd_chk("post_cnt", 5'h08, 0);
      rd_chk("post_ctrl", 5'h0C, 0);
      chk("post_irq", 32'(irq), 0);

      chk("bus_protocol", stab_err, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
